// File: rtl/operand_fetch_if.sv
// operand_fetch_if: groups the decode request, writeback, register-file and execute
// handshake signals of operand_fetch.
//   master: operand_fetch side (drives in_ready, rf_* outputs, out_valid, out_rs1/2)
//   slave : environment side (decode, writeback, register file, execute)
interface operand_fetch_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic        in_use_rs1;
  logic        in_use_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [31:0] rf_rs1_addr;
  logic [31:0] rf_rs2_addr;
  logic [31:0] rf_rs1;
  logic [31:0] rf_rs2;
  logic [31:0] rf_rd;
  logic [31:0] rf_rd_data;
  logic        rf_rd_write;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rs1;
  logic [31:0] out_rs2;
  modport master (
    input  in_valid, in_rs1_addr, in_rs2_addr, in_use_rs1, in_use_rs2,
    input  wb_valid, wb_rd, wb_data, rf_rs1, rf_rs2, out_ready,
    output in_ready, rf_rs1_addr, rf_rs2_addr, rf_rd, rf_rd_data, rf_rd_write,
    output out_valid, out_rs1, out_rs2
  );
  modport slave (
    output in_valid, in_rs1_addr, in_rs2_addr, in_use_rs1, in_use_rs2,
    output wb_valid, wb_rd, wb_data, rf_rs1, rf_rs2, out_ready,
    input  in_ready, rf_rs1_addr, rf_rs2_addr, rf_rd, rf_rd_data, rf_rd_write,
    input  out_valid, out_rs1, out_rs2
  );
endinterface

// File: rtl/operand_fetch.sv
// operand_fetch: fetches two source operands from a synchronous-read register file,
// forwards writebacks into the file and bypasses writes the read latency would miss.
//   clk, reset : clock, synchronous active-high reset
//   bus        : operand_fetch_if.master (request, writeback, register file, operands)
// Optional: OPFETCH_HOLD_FWD_EN keeps held operands current with writebacks while
// waiting for the consumer; otherwise held operands stay frozen until the handshake.
module operand_fetch (
  input logic clk,
  input logic reset,
  operand_fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;
  state_t state;
  logic [4:0] a1, a2;
  logic u1, u2, f1, f2;
  logic [31:0] b1, b2, sel1, sel2;
  logic hit1, hit2, accept;
  assign hit1 = bus.wb_valid && (a1 != 5'd0) && (bus.wb_rd == a1);
  assign hit2 = bus.wb_valid && (a2 != 5'd0) && (bus.wb_rd == a2);
  assign bus.in_ready = (state == IDLE) || (state == HOLD && bus.out_ready);
  assign accept = bus.in_valid && bus.in_ready;
  assign bus.rf_rs1_addr = {27'd0, a1};
  assign bus.rf_rs2_addr = {27'd0, a2};
  assign bus.rf_rd = {27'd0, bus.wb_rd};
  assign bus.rf_rd_data = bus.wb_data;
  assign bus.rf_rd_write = bus.wb_valid && (|bus.wb_rd) && !reset;
  // A write landing at the capture edge is newer than any bypass or array value.
  assign sel1 = (!u1 || a1 == 5'd0) ? 32'd0 : hit1 ? bus.wb_data : f1 ? b1 : bus.rf_rs1;
  assign sel2 = (!u2 || a2 == 5'd0) ? 32'd0 : hit2 ? bus.wb_data : f2 ? b2 : bus.rf_rs2;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a1 <= 5'd0;
      a2 <= 5'd0;
      u1 <= 1'b0;
      u2 <= 1'b0;
      f1 <= 1'b0;
      f2 <= 1'b0;
      b1 <= 32'd0;
      b2 <= 32'd0;
      bus.out_valid <= 1'b0;
      bus.out_rs1 <= 32'd0;
      bus.out_rs2 <= 32'd0;
    end else begin
      if (accept) begin
        a1 <= bus.in_rs1_addr;
        a2 <= bus.in_rs2_addr;
        u1 <= bus.in_use_rs1;
        u2 <= bus.in_use_rs2;
        f1 <= 1'b0;
        f2 <= 1'b0;
      end
      case (state)
        IDLE: if (accept) state <= ADDR;
        ADDR: begin
          // The array returns the pre-write value for a write at this edge.
          if (hit1) begin
            b1 <= bus.wb_data;
            f1 <= 1'b1;
          end
          if (hit2) begin
            b2 <= bus.wb_data;
            f2 <= 1'b1;
          end
          state <= DATA;
        end
        DATA: begin
          bus.out_rs1 <= sel1;
          bus.out_rs2 <= sel2;
          bus.out_valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
`ifdef OPFETCH_HOLD_FWD_EN
          if (hit1 && u1) bus.out_rs1 <= bus.wb_data;
          if (hit2 && u2) bus.out_rs2 <= bus.wb_data;
`endif
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            state <= accept ? ADDR : IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: doc/operand_fetch.md
# operand_fetch

Initiator side of the register-file read/write interface. Accepts decoded source-register requests, drives the register file's synchronous read ports, and returns operands on a valid/ready handshake. It also forwards writeback traffic into the register file and bypasses writebacks that the one-cycle read latency would otherwise miss. It sits between decode and execute in the RISC-V core.

## Interface
- No parameters; data width fixed at 32, register index 5 bits, 32 registers, x0 hardwired to zero.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  request present
- in_ready  out  1  request accepted when in_valid & in_ready at a rising edge
- in_rs1_addr, in_rs2_addr  in  5  source indices
- in_use_rs1, in_use_rs2  in  1  operand required; if 0, that operand returns 0
- wb_valid  in  1  writeback strobe
- wb_rd  in  5  writeback index
- wb_data  in  32  writeback value
- rf_rs1_addr, rf_rs2_addr  out  32  to register-file read ports; index in [4:0], upper bits 0
- rf_rs1, rf_rs2  in  32  register-file read data, registered, valid one cycle after address
- rf_rd  out  32  write index, zero-extended wb_rd
- rf_rd_data  out  32  = wb_data
- rf_rd_write  out  1  = wb_valid & (wb_rd != 0) & ~reset; combinational
- out_valid  out  1  operands valid
- out_ready  in  1  consumer accepts
- out_rs1, out_rs2  out  32  operands

## Operation
- Reset (synchronous): state IDLE; in_ready 1 after reset deasserts; out_valid 0; out_rs1/out_rs2 0; rf_rs*_addr 0; bypass flags cleared. Assertion mid-transaction discards the request. Writes are suppressed while reset is high.
- States:
  - IDLE: in_ready=1. Accept → latch addresses/use bits into rf_rs*_addr → ADDR.
  - ADDR: register file samples addresses at the end of this cycle. A wb to a matching nonzero index is captured into bypass register b1/b2 with its flag set, because the register file returns the pre-write value. → DATA.
  - DATA: capture operands at the clock edge. Priority: use=0 or index 0 → 0; wb matching in this cycle → wb_data; flag set → bypass value; otherwise rf_rs*. Set out_valid → HOLD.
  - HOLD: out_valid=1, in_ready=out_ready. On out_valid & out_ready: if in_valid, accept the new request → ADDR; otherwise → IDLE. out_valid drops the cycle after the handshake.
- A wb in the acceptance cycle (IDLE/HOLD) lands in the array before the ADDR read, so no bypass is needed.
- Writes to index 0 are never written and never forwarded.
- A later bypass in the same transaction overrides an earlier one (last write wins).

## Timing
- Latency: accept at edge E0 → out_valid high from edge E2, i.e. 2 cycles.
- Peak throughput is one operand pair per 3 cycles, with back-to-back acceptance in the HOLD handshake cycle.
- out_rs* stable while out_valid & ~out_ready, except as described in Configuration.
- in_ready is 0 in ADDR and DATA. In HOLD it depends combinationally on out_ready; there is no other combinational in→out path.

## Configuration
- OPFETCH_HOLD_FWD_EN defined: in HOLD, a wb to a matching nonzero index with use=1 updates the held operand at that edge. The consumer therefore always sees the latest architectural value.
- Undefined: held operands are frozen from DATA until the handshake.

## Test plan
- Reset, then request rs1=2, rs2=3 with array x2=2, x3=3, out_ready=1 → out_valid at E2, out_rs1=2, out_rs2=3; in_ready low for two cycles.
- Request rs1=0, use_rs2=0, with a wb to x0 of 0xDEAD → out_rs1=0, out_rs2=0, rf_rd_write never asserted.
- wb x5=0x11 in the ADDR cycle, request rs1=5 with stale array 0 → out_rs1=0x11. Repeat with wb x5=0x22 in the DATA cycle → 0x22. With both writes → 0x22.
- Hold out_ready=0 for 4 cycles and issue wb x5=0x33 during HOLD → 0x33 with OPFETCH_HOLD_FWD_EN, old value without; in_ready=0 throughout.
- Two back-to-back requests with in_valid held and out_ready=1 → second accepted on the first's handshake edge, outputs spaced 3 cycles apart.
- Assert reset during DATA → next cycle out_valid=0, out_rs*=0, state IDLE; a subsequent request completes normally.
